// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared types, constants and CRC-16 byte step for the PPM frame controller
package ppm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_DRAIN,
    ST_FLUSH
  } state_e;

  localparam logic [1:0]  ERR_CRC     = 2'b01;
  localparam logic [1:0]  ERR_LEN     = 2'b10;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b11;

  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'h8408;
  localparam logic [15:0] CRC_RESIDUE = 16'hF0B8;

  // One byte of CRC-16/ISO-13239, LSB first with the reflected polynomial.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ppm_crc16.sv
// rtl/ppm_crc16.sv - byte-wide CRC-16 register, one byte per cycle
//  clk, rst_n : clock, asynchronous active-low reset
//  init_i     : load CRC_INIT (wins over en_i)
//  en_i       : fold data_i into the register
//  data_i     : byte to fold in
//  crc_o      : current register value
module ppm_crc16
  import ppm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else if (init_i) begin
      crc_q <= CRC_INIT;
    end else if (en_i) begin
      crc_q <= crc16_byte(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ppm_frame_ctrl.sv
// rtl/ppm_frame_ctrl.sv - captures decoded frames, checks length/CRC, streams good payloads
//  clk, rst_n          : clock, asynchronous active-low reset
//  Dout, D_en, F_en    : decoded byte, byte strobe, frame window from the decoder
//  rx_data/valid/ready : payload byte stream to host, rx_last on final payload byte
//  frame_err, err_code : discard pulse and held reason (01 CRC, 10 LEN, 11 TIMEOUT)
//  busy                : controller not idle
//  drop_pulse          : a frame window opened while busy and was ignored
module ppm_frame_ctrl
  import ppm_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int MIN_LEN     = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Dout,
  input  logic       D_en,
  input  logic       F_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_last,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic       drop_pulse
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [PW-1:0] MAX_PTR    = PW'(MAX_LEN);
  localparam logic [PW-1:0] MIN_PTR    = PW'(MIN_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q;
  logic          fen_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    pend_err_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_last_q;
  logic          frame_err_q;
  logic [1:0]    err_code_q;
  logic          drop_pulse_q;
  logic [7:0]    mem_q [MAX_LEN];

  logic          f_rise;
  logic          f_fall;
  logic          wr_full;
  logic          wr_en;
  logic          crc_init;
  logic [15:0]   crc;
  logic [PW-1:0] last_idx;
  logic [PW-1:0] rd_next;

  assign f_rise   = F_en & ~fen_q;
  assign f_fall   = ~F_en & fen_q;
  assign wr_full  = (wr_ptr_q == MAX_PTR);
  assign wr_en    = (state_q == ST_RECV) && D_en && !wr_full;
  assign crc_init = (state_q == ST_IDLE) && f_rise;
  // Payload excludes the two trailing CRC bytes.
  assign last_idx = wr_ptr_q - PW'(3);
  assign rd_next  = rd_ptr_q + PW'(1);

  ppm_crc16 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (crc_init),
    .en_i   (wr_en),
    .data_i (Dout),
    .crc_o  (crc)
  );

  // Frame buffer needs no reset: reads are bounded by wr_ptr_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= Dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fen_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      timer_q      <= '0;
      pend_err_q   <= 2'b00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_last_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 2'b00;
      drop_pulse_q <= 1'b0;
    end else begin
      fen_q        <= F_en;
      frame_err_q  <= 1'b0;
      drop_pulse_q <= f_rise && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (f_rise) begin
            state_q  <= ST_RECV;
            wr_ptr_q <= '0;
            timer_q  <= '0;
          end
        end
        ST_RECV: begin
          if (D_en && wr_full) begin
            pend_err_q <= ERR_LEN;
            state_q    <= ST_FLUSH;
          end else if (D_en) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            timer_q  <= '0;
            if (f_fall) state_q <= ST_CHECK;
          end else if (f_fall) begin
            state_q <= ST_CHECK;
          end else if (timer_q == TIMER_LAST) begin
            pend_err_q <= ERR_TIMEOUT;
            state_q    <= ST_FLUSH;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_CHECK: begin
          if (wr_ptr_q < MIN_PTR) begin
            pend_err_q <= ERR_LEN;
            state_q    <= ST_FLUSH;
          end else if (crc != CRC_RESIDUE) begin
            pend_err_q <= ERR_CRC;
            state_q    <= ST_FLUSH;
          end else begin
            state_q    <= ST_DRAIN;
            rd_ptr_q   <= '0;
            rx_data_q  <= mem_q[0];
            rx_valid_q <= 1'b1;
            rx_last_q  <= (last_idx == '0);
          end
        end
        ST_DRAIN: begin
          if (rx_ready) begin
            if (rx_last_q) begin
              rx_valid_q <= 1'b0;
              rx_last_q  <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              rd_ptr_q  <= rd_next;
              rx_data_q <= mem_q[rd_next[AW-1:0]];
              rx_last_q <= (rd_next == last_idx);
            end
          end
        end
        ST_FLUSH: begin
          frame_err_q <= 1'b1;
          err_code_q  <= pend_err_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_last    = rx_last_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign drop_pulse = drop_pulse_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// tb/tb_ppm_frame_ctrl.sv - scoreboard bench for ppm_frame_ctrl
module tb_ppm_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Dout = 8'h00;
  logic       D_en = 1'b0;
  logic       F_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       rx_last;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic       drop_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int drop_seen = 0;
  logic ready_toggle = 1'b0;

  logic [8:0] exp_q [$];
  logic [1:0] err_q [$];
  logic [7:0] fr [$];

  logic       stalled = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  ppm_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Dout       (Dout),
    .D_en       (D_en),
    .F_en       (F_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_last    (rx_last),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rx_ready = ready_toggle ? ~rx_ready : 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a byte or an error.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_data_stable", rx_data, prev_data);
        check("stall_last_stable", rx_last, prev_last);
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rx_byte", rx_data, 9'h1FF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rx_data", rx_data, e[7:0]);
          check("rx_last", rx_last, e[8]);
        end
      end
      stalled   = rx_valid && !rx_ready;
      prev_data = rx_data;
      prev_last = rx_last;
      if (frame_err) begin
        if (err_q.size() == 0) begin
          check("unexpected_frame_err", err_code, 0);
        end else begin
          check("err_code", err_code, err_q.pop_front());
        end
      end
      if (drop_pulse) drop_seen++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    Dout = b;
    D_en = 1'b1;
    tick();
    D_en = 1'b0;
    tick();
  endtask

  task automatic send_frame;
    F_en = 1'b1;
    tick();
    tick();
    foreach (fr[i]) send_byte(fr[i]);
    F_en = 1'b0;
  endtask

  task automatic expect_good;
    for (int i = 0; i < fr.size() - 2; i++) begin
      exp_q.push_back({(i == fr.size() - 3), fr[i]});
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, "_timeout"}, 1, 0);
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_last", rx_last, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_pulse, 0);
    rst_n = 1'b1;
    tick();

    // Good frame, with EOF-to-first-valid latency.
    fr = '{8'h26, 8'h01, 8'h00, 8'hF6, 8'h0A};
    expect_good();
    send_frame();
    @(posedge clk);
    @(negedge clk);
    check("latency_cycle1", rx_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("latency_cycle2", rx_valid, 1);
    wait_idle("good1", 50);

    // Corrupted CRC byte.
    fr = '{8'h26, 8'h01, 8'h00, 8'hF6, 8'h0B};
    err_q.push_back(2'b01);
    send_frame();
    wait_idle("crc", 50);
    tick();
    check("err_code_held", err_code, 2'b01);

    // Too short.
    fr = '{8'hF6, 8'h0A};
    err_q.push_back(2'b10);
    send_frame();
    wait_idle("short", 50);

    // Too long: error fires on byte 33.
    err_q.push_back(2'b10);
    F_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    check("len_not_before_33", err_q.size(), 1);
    check("busy_at_32", busy, 1);
    send_byte(8'hAA);
    wait_idle("long", 20);
    check("len_err_at_33", err_q.size(), 0);
    F_en = 1'b0;
    tick();

    // Timeout after one byte.
    err_q.push_back(2'b11);
    F_en = 1'b1;
    tick();
    tick();
    send_byte(8'h55);
    wait_idle("timeout", 5000);
    check("timeout_err_code", err_code, 2'b11);
    F_en = 1'b0;
    tick();

    // Good frame with stalling host, second window during drain is dropped.
    fr = '{8'h26, 8'h01, 8'h00, 8'hF6, 8'h0A};
    expect_good();
    ready_toggle = 1'b1;
    send_frame();
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rx_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("drain_started", rx_valid, 1);
    end
    tick();
    F_en = 1'b1;
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    F_en = 1'b0;
    wait_idle("drop", 50);
    ready_toggle = 1'b0;
    tick();
    tick();
    check("drop_count", drop_seen, 1);

    // Reset mid-frame, then a good frame.
    F_en = 1'b1;
    tick();
    tick();
    send_byte(8'h26);
    send_byte(8'h01);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_err_code", err_code, 0);
    check("midrst_frame_err", frame_err, 0);
    F_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    fr = '{8'h26, 8'h01, 8'h00, 8'hF6, 8'h0A};
    expect_good();
    send_frame();
    wait_idle("after_rst", 50);
    tick();

    check("exp_bytes_left", exp_q.size(), 0);
    check("exp_errs_left", err_q.size(), 0);
    check("final_drop_count", drop_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
